// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Handshake bundle for the ALU issue stage.
//   in_*  : decoded instruction from ID (valid/ready), source operands,
//           immediate, op code and destination.
//   out_* : captured ALU result toward MEM/WB (valid/ready).
//   master: the ID / downstream side.  slave: the issue stage itself.
interface alu_issue_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic              in_use_imm;
  logic [3:0]        in_op;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic              out_zero;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_op, in_rd, in_reg_write, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_op, in_rd, in_reg_write, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand-issue / result-capture stage around the combinational RV32I ALU.
//   ISS register presents alu_a/alu_b/alu_op to the ALU; RES register
//   captures alu_result/alu_zero toward MEM/WB.
//   Ports:
//     clk, rst_n        : clock, async active-low reset
//     io (slave)        : in_* instruction handshake, out_* result handshake
//     alu_a/alu_b/alu_op: registered ALU operands (ISS)
//     alu_result/zero   : combinational ALU response
//     wb_rd/wb_data/wb_reg_write : writeback bus, used for forwarding/hazards
//   Build option:
//     ALU_FWD_EN defined  : operands forwarded from ISS, RES and WB.
//     ALU_FWD_EN undefined: operands straight from the register file; any
//                           RAW against ISS/RES/WB stalls in_ready.
`ifndef ALU_ADD_OP
`define ALU_ADD_OP  4'd0
`define ALU_SUB_OP  4'd1
`define ALU_AND_OP  4'd2
`define ALU_OR_OP   4'd3
`define ALU_XOR_OP  4'd4
`define ALU_SLL_OP  4'd5
`define ALU_SRL_OP  4'd6
`define ALU_SRA_OP  4'd7
`define ALU_SLT_OP  4'd8
`define ALU_SLTU_OP 4'd9
`endif

module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  io,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              wb_reg_write
);
  localparam int NSRC = 2;  // 0: rs1, 1: rs2

  logic              iss_valid_q, iss_valid_d;
  logic [REG_AW-1:0] iss_rd_q, iss_rd_d;
  logic              iss_reg_write_q, iss_reg_write_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic              out_zero_q, out_zero_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  logic              out_reg_write_q, out_reg_write_d;

  logic res_adv, in_xfer, hazard, in_ready;

  logic [NSRC-1:0][REG_AW-1:0] src_rs;
  logic [NSRC-1:0][XLEN-1:0]   src_rf;
  logic [NSRC-1:0][XLEN-1:0]   src_val;
  logic [NSRC-1:0]             src_used;
  logic [NSRC-1:0]             src_live;
  // per source: [0] ISS match, [1] RES match, [2] WB match (priority order)
  logic [NSRC-1:0][2:0]        src_hit;

  assign src_rs   = {io.in_rs2, io.in_rs1};
  assign src_rf   = {io.in_rs2_data, io.in_rs1_data};
  assign src_used = {!io.in_use_imm, 1'b1};

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      // x0 is never a producer: it always reads the register-file zero
      assign src_live[i]   = src_used[i] & (src_rs[i] != '0);
      assign src_hit[i][0] = src_live[i] & iss_valid_q & iss_reg_write_q & (iss_rd_q == src_rs[i]);
      assign src_hit[i][1] = src_live[i] & out_valid_q & out_reg_write_q & (out_rd_q == src_rs[i]);
      assign src_hit[i][2] = src_live[i] & wb_reg_write & (wb_rd == src_rs[i]);
`ifdef ALU_FWD_EN
      // An ISS hit only matters when ISS advances this cycle; if it holds,
      // in_ready is already low and nothing is accepted.
      assign src_val[i] = src_hit[i][0] ? alu_result   :
                          src_hit[i][1] ? out_result_q :
                          src_hit[i][2] ? wb_data      : src_rf[i];
`else
      assign src_val[i] = src_rf[i];
`endif
    end
  endgenerate

`ifdef ALU_FWD_EN
  assign hazard = 1'b0;
`else
  assign hazard = |src_hit;
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign res_adv  = !out_valid_q | io.out_ready;
  assign in_ready = (!iss_valid_q | res_adv) & !hazard;
  assign in_xfer  = io.in_valid & in_ready;

  always_comb begin
    iss_valid_d     = iss_valid_q;
    iss_rd_d        = iss_rd_q;
    iss_reg_write_d = iss_reg_write_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_op_d        = alu_op_q;
    if (in_xfer) begin
      iss_valid_d     = 1'b1;
      iss_rd_d        = io.in_rd;
      iss_reg_write_d = io.in_reg_write;
      alu_a_d         = src_val[0];
      alu_b_d         = io.in_use_imm ? io.in_imm : src_val[1];
      alu_op_d        = io.in_op;
    end else if (res_adv) begin
      iss_valid_d = 1'b0;
    end

    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_zero_d      = out_zero_q;
    out_rd_d        = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    if (res_adv) begin
      out_valid_d = iss_valid_q;
      if (iss_valid_q) begin
        out_result_d    = alu_result;
        out_zero_d      = alu_zero;
        out_rd_d        = iss_rd_q;
        out_reg_write_d = iss_reg_write_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q     <= 1'b0;
      iss_rd_q        <= '0;
      iss_reg_write_q <= 1'b0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_op_q        <= `ALU_ADD_OP;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_zero_q      <= 1'b0;
      out_rd_q        <= '0;
      out_reg_write_q <= 1'b0;
    end else begin
      iss_valid_q     <= iss_valid_d;
      iss_rd_q        <= iss_rd_d;
      iss_reg_write_q <= iss_reg_write_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_op_q        <= alu_op_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_zero_q      <= out_zero_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
    end
  end

  assign io.in_ready      = in_ready;
  assign io.out_valid     = out_valid_q;
  assign io.out_result    = out_result_q;
  assign io.out_zero      = out_zero_q;
  assign io.out_rd        = out_rd_q;
  assign io.out_reg_write = out_reg_write_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_op           = alu_op_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Bench for alu_issue_stage: behavioural ALU, register file and WB stage,
//   architectural model feeding a result scoreboard, per-scenario tasks.
module tb_alu_issue_stage;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0]   res;
    logic              zero;
    logic [REG_AW-1:0] rd;
    logic              rw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) io ();
  logic [XLEN-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]        alu_op;
  logic              alu_zero;
  logic [REG_AW-1:0] wb_rd = '0;
  logic [XLEN-1:0]   wb_data = '0;
  logic              wb_reg_write = 1'b0;

  alu_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write)
  );

  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] arch [32];
  logic [XLEN-1:0] arch_save [32];

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: return {{(XLEN-1){1'b0}}, a < b};
      default: return a + b;
    endcase
  endfunction

  assign alu_result     = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero       = (alu_result == '0);
  assign io.in_rs1_data = rf[io.in_rs1];
  assign io.in_rs2_data = rf[io.in_rs2];

  // Monitor: pop and compare on every output transfer; remember it for WB.
  logic              wb_pend = 1'b0;
  logic [REG_AW-1:0] wb_pend_rd = '0;
  logic [XLEN-1:0]   wb_pend_data = '0;
  always @(negedge clk) begin
    exp_t e;
    wb_pend = 1'b0;
    if (rst_n && io.out_valid && io.out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got res=%h rd=%0d with empty queue", io.out_result, io.out_rd);
      end else begin
        e = sb.pop_front();
        if ({io.out_result, io.out_zero, io.out_rd, io.out_reg_write} !== e) begin
          n_fail++;
          $display("FAIL sb_result: got res=%h z=%b rd=%0d rw=%b want res=%h z=%b rd=%0d rw=%b",
                   io.out_result, io.out_zero, io.out_rd, io.out_reg_write, e.res, e.zero, e.rd, e.rw);
        end
      end
      wb_pend      = io.out_reg_write;
      wb_pend_rd   = io.out_rd;
      wb_pend_data = io.out_result;
    end
  end

  // WB stage: one cycle after the output transfer, then commits to the RF.
  always @(posedge clk) begin
    #1;
    if (wb_reg_write && wb_rd != '0) rf[wb_rd] = wb_data;
    wb_reg_write = wb_pend & rst_n;
    wb_rd        = wb_pend_rd;
    wb_data      = wb_pend_data;
  end

  function automatic void sb_push(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm, input logic rw);
    exp_t e;
    e.res  = alu_f(op, arch[rs1], use_imm ? imm : arch[rs2]);
    e.zero = (e.res == '0);
    e.rd   = rd;
    e.rw   = rw;
    sb.push_back(e);
    if (rw && rd != 5'd0) arch[rd] = e.res;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm, input logic rw);
    io.in_op = op; io.in_rd = rd; io.in_rs1 = rs1; io.in_rs2 = rs2;
    io.in_imm = imm; io.in_use_imm = use_imm; io.in_reg_write = rw; io.in_valid = 1'b1;
    sb_push(op, rd, rs1, rs2, imm, use_imm, rw);
  endtask

  // Offer one instruction, wait (bounded) for in_ready, return stall cycles.
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm,
                      input logic rw, output int stalls);
    int n;
    drive(op, rd, rs1, rs2, imm, use_imm, rw);
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 40) begin n++; @(negedge clk); end
    if (!io.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %b, want 1", io.in_ready);
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    stalls = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || io.out_valid) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: queue=%0d out_valid=%b, want 0/0", sb.size(), io.out_valid);
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (io.out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", io.out_valid); end
    n_tests++; if (io.in_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", io.in_ready); end
    n_tests++; if (alu_a !== '0)              begin n_fail++; $display("FAIL rst_alu_a: got %h want 0", alu_a); end
    n_tests++; if (alu_b !== '0)              begin n_fail++; $display("FAIL rst_alu_b: got %h want 0", alu_b); end
    n_tests++; if (alu_op !== OP_ADD)         begin n_fail++; $display("FAIL rst_alu_op: got %h want %h", alu_op, OP_ADD); end
    n_tests++; if (io.out_result !== '0)      begin n_fail++; $display("FAIL rst_out_result: got %h want 0", io.out_result); end
    n_tests++; if (io.out_zero !== 1'b0)      begin n_fail++; $display("FAIL rst_out_zero: got %b want 0", io.out_zero); end
    n_tests++; if (io.out_rd !== '0)          begin n_fail++; $display("FAIL rst_out_rd: got %0d want 0", io.out_rd); end
    n_tests++; if (io.out_reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_out_rw: got %b want 0", io.out_reg_write); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    drive(OP_ADD, 5'd1, 5'd10, 5'd11, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", io.in_ready); end
    @(posedge clk); #1;
    drive(OP_XOR, 5'd12, 5'd2, 5'd0, 32'hF, 1'b1, 1'b1);
    @(negedge clk);
    n_tests++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== OP_ADD)
      begin n_fail++; $display("FAIL b2b_iss_add: got a=%h b=%h op=%h want 5/3/%h", alu_a, alu_b, alu_op, OP_ADD); end
    n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_lat1: out_valid got %b want 0", io.out_valid); end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_lat2: out_valid got %b want 1", io.out_valid); end
    n_tests++; if (alu_a !== 32'hA0 || alu_b !== 32'hF || alu_op !== OP_XOR)
      begin n_fail++; $display("FAIL b2b_iss_xor: got a=%h b=%h op=%h want a0/f/%h", alu_a, alu_b, alu_op, OP_XOR); end
    @(negedge clk);
    n_tests++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: out_valid got %b want 1", io.out_valid); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_iss_forward();
    int s, want;
    send(OP_ADD, 5'd3, 5'd7, 5'd0, 32'd1, 1'b1, 1'b1, s);
    send(OP_SUB, 5'd4, 5'd3, 5'd8, 32'd0, 1'b0, 1'b1, s);
`ifdef ALU_FWD_EN
    want = 0;
`else
    want = 3;
`endif
    n_tests++; if (s !== want) begin n_fail++; $display("FAIL fwd_iss_stall: got %0d cycles want %0d", s, want); end
    drain();
  endtask

  task automatic test_priority();
    int s, want;
    send(OP_ADD, 5'd5, 5'd0, 5'd0, 32'h10, 1'b1, 1'b1, s);
    send(OP_ADD, 5'd5, 5'd0, 5'd0, 32'h20, 1'b1, 1'b1, s);
    send(OP_ADD, 5'd9, 5'd5, 5'd0, 32'h0, 1'b0, 1'b1, s);
    @(negedge clk);
    n_tests++; if (alu_a !== 32'h20) begin n_fail++; $display("FAIL prio_operand: got %h want 20", alu_a); end
`ifdef ALU_FWD_EN
    want = 0;
`else
    want = 3;
`endif
    n_tests++; if (s !== want) begin n_fail++; $display("FAIL prio_stall: got %0d cycles want %0d", s, want); end
    @(posedge clk); #1;
    drain();
    send(OP_ADD, 5'd0, 5'd7, 5'd0, 32'h55, 1'b1, 1'b1, s);
    send(OP_OR, 5'd14, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, s);
    @(negedge clk);
    n_tests++; if (alu_a !== '0 || alu_b !== '0) begin n_fail++; $display("FAIL x0_operand: got a=%h b=%h want 0/0", alu_a, alu_b); end
    n_tests++; if (s !== 0) begin n_fail++; $display("FAIL x0_stall: got %0d cycles want 0", s); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    int s;
    io.out_ready = 1'b0;
    send(OP_ADD, 5'd16, 5'd10, 5'd11, 32'h0, 1'b0, 1'b1, s);
    send(OP_SUB, 5'd17, 5'd2, 5'd0, 32'h20, 1'b1, 1'b1, s);
    drive(OP_AND, 5'd15, 5'd2, 5'd10, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (io.in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, io.in_ready); end
      n_tests++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, io.out_valid); end
      n_tests++; if (io.out_result !== 32'd8) begin n_fail++; $display("FAIL bp_out_result[%0d]: got %h want 8", k, io.out_result); end
      n_tests++; if (alu_a !== 32'hA0 || alu_b !== 32'h20 || alu_op !== OP_SUB)
        begin n_fail++; $display("FAIL bp_iss_hold[%0d]: got a=%h b=%h op=%h want a0/20/%h", k, alu_a, alu_b, alu_op, OP_SUB); end
    end
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (io.out_valid !== 1'b1 || io.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 1/1", io.out_valid, io.in_ready); end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain[%0d]: out_valid got %b want 1", k, io.out_valid); end
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_raw_hazard();
    int s, want;
    send(OP_ADD, 5'd6, 5'd10, 5'd11, 32'h0, 1'b0, 1'b1, s);
    send(OP_AND, 5'd18, 5'd6, 5'd0, 32'hC, 1'b1, 1'b1, s);
`ifdef ALU_FWD_EN
    want = 0;
`else
    want = 3;
`endif
    n_tests++; if (s !== want) begin n_fail++; $display("FAIL raw_stall: got %0d cycles want %0d", s, want); end
    drain();
  endtask

  task automatic test_reset_midflight();
    int s;
    arch_save = arch;
    send(OP_ADD, 5'd20, 5'd10, 5'd11, 32'h0, 1'b0, 1'b1, s);
    send(OP_OR, 5'd21, 5'd2, 5'd0, 32'h1, 1'b1, 1'b1, s);
    n_tests++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: out_valid got %b want 1", io.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", io.out_valid); end
    n_tests++; if (alu_op !== OP_ADD)     begin n_fail++; $display("FAIL mid_alu_op: got %h want %h", alu_op, OP_ADD); end
    n_tests++; if (alu_a !== '0 || io.out_result !== '0)
      begin n_fail++; $display("FAIL mid_regs: got a=%h res=%h want 0/0", alu_a, io.out_result); end
    sb.delete();
    arch = arch_save;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(OP_SUB, 5'd22, 5'd10, 5'd11, 32'h0, 1'b0, 1'b1, s);
    n_tests++; if (s !== 0) begin n_fail++; $display("FAIL mid_first_accept: got %0d stall cycles want 0", s); end
    @(negedge clk);
    n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1: out_valid got %b want 0", io.out_valid); end
    @(negedge clk);
    n_tests++; if (io.out_valid !== 1'b1 || io.out_result !== 32'd2)
      begin n_fail++; $display("FAIL mid_lat2: got valid=%b res=%h want 1/2", io.out_valid, io.out_result); end
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[2] = 32'hA0; rf[7] = 32'd7; rf[8] = 32'd8; rf[10] = 32'd5; rf[11] = 32'd3;
    arch = rf;
    io.in_valid = 1'b0; io.in_rs1 = '0; io.in_rs2 = '0; io.in_imm = '0;
    io.in_use_imm = 1'b0; io.in_op = OP_ADD; io.in_rd = '0; io.in_reg_write = 1'b0;
    io.out_ready = 1'b1;

    test_reset();
    test_back_to_back();
    test_iss_forward();
    test_priority();
    test_backpressure();
    test_raw_hazard();
    test_reset_midflight();

    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue and result-capture stage wrapped around the combinational ALU in the RV32I core.
- Accepts decoded instructions from ID over a valid/ready handshake and resolves register operands, with forwarding from in-flight results and from writeback.
- Drives alu_a/alu_b/alu_op into the ALU, then captures its result and zero flag into an output register toward MEM/WB.
- Two register stages: ISS (operands presented to the ALU) and RES (captured result).

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction offered by ID.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs1, in_rs2  in  REG_AW  source register addresses.
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_use_imm  in  1  1: operand b = in_imm; 0: operand b = rs2.
- in_op  in  4  ALU op code, using the ALU_*_OP defines.
- in_rd  in  REG_AW  destination register.
- in_reg_write  in  1  instruction writes rd.
- alu_a, alu_b  out  XLEN  operands to the ALU, registered in ISS.
- alu_op  out  4  op code to the ALU, registered in ISS.
- alu_result  in  XLEN  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_zero  in  1  ALU zero flag.
- wb_rd  in  REG_AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- wb_reg_write  in  1  writeback valid.
- out_valid  out  1  RES holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_result  out  XLEN  captured result.
- out_zero  out  1  captured zero flag.
- out_rd  out  REG_AW  captured destination register.
- out_reg_write  out  1  captured write enable.

Behaviour:
- Reset (async, rst_n=0): iss_valid=0, out_valid=0, alu_a=0, alu_b=0, alu_op=ALU_ADD_OP, out_result=0, out_zero=0, out_rd=0, out_reg_write=0. In-flight instructions are dropped. First accept is possible on the first rising edge after rst_n deasserts.
- Handshakes:
  - res_adv = !out_valid | out_ready.
  - in_ready = !iss_valid | res_adv, combinational.
  - Input transfers on in_valid & in_ready.
  - Output transfers on out_valid & out_ready.
- ISS→RES: when iss_valid & res_adv, RES loads alu_result/alu_zero/iss_rd/iss_reg_write and out_valid<=1. When res_adv & !iss_valid, out_valid<=0.
- ISS load: on input transfer, ISS loads the resolved operands and iss_valid<=1. When res_adv & no input transfer, iss_valid<=0. Otherwise ISS holds and alu_a/alu_b/alu_op stay stable.
- Latency: accept in cycle N → ALU sees operands in cycle N+1 → out_valid in cycle N+2. Throughput is 1 instruction per cycle with no backpressure.
- Forwarding: each source rs1, and rs2 when !in_use_imm, is resolved in priority order:
  1. iss_valid & iss_reg_write & iss_rd==rs → alu_result. Only when ISS advances this same cycle; otherwise in_ready is already 0.
  2. out_valid & out_reg_write & out_rd==rs → out_result.
  3. wb_reg_write & wb_rd==rs → wb_data.
  4. Otherwise the register-file data.
- rs==0 is never forwarded; operand is register-file data (x0 reads 0).
- out_ready held low: ISS and RES both hold, in_ready=0, and all outputs stay stable.
- Widths: no arithmetic in this block; the ALU handles all results modulo 2^XLEN.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined: no forwarding muxes; operands come straight from the register file. Add to in_ready: in_ready &= !hazard, where hazard = any used source rs≠0 matching a valid ISS, RES or WB destination with reg_write set. The bench must see in_ready=0 until the producer has left WB.

Test Plan:
- Reset mid-flight: two instructions in flight, pull rst_n low asynchronously → out_valid=0 and alu_op=ALU_ADD_OP immediately; after release the next accept gives out_valid two cycles later.
- Back-to-back independent ops: ADD x1=5+3, then XOR with imm 0xF on x2=0xA0 → out_result 8, then 0xAF, in consecutive cycles, zero=0.
- Dependency ISS forward: ADD x3=7+1, then SUB x4=x3-8 issued next cycle → second result 0, out_zero=1 (ALU_FWD_EN defined).
- Priority: x5 pending in both RES (value 0x10) and ISS (value 0x20); new op reads x5 → operand 0x20. x0 target with reg_write: a reader of x0 gets 0.
- Backpressure: out_ready=0 for 3 cycles with ISS and RES full → in_ready=0 and out_result stable; release → results drain in order, one per cycle.
- ALU_FWD_EN undefined: RAW on x6 → in_ready=0 for 3 cycles (ISS, RES, WB), then accepted with register-file data.
